// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shared memory port arbiter between instruction fetch and data memory
// Round-robin, one outstanding transaction, fixed read latency, single response pulse per grant.
module mem_port_arbiter #(
  parameter int WIDTH   = 32,
  parameter int MEM_LAT = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             if_req,
  input  logic [WIDTH-1:0] if_addr,
  output logic             if_gnt,
  output logic             if_rvalid,
  input  logic             dm_req,
  input  logic             dm_we,
  input  logic [WIDTH-1:0] dm_addr,
  input  logic [WIDTH-1:0] dm_wdata,
  output logic             dm_gnt,
  output logic             dm_rvalid,
  output logic [WIDTH-1:0] rdata,
  output logic             sel,
  output logic             mem_en,
  output logic             mem_we,
  output logic [WIDTH-1:0] mem_addr,
  output logic [WIDTH-1:0] mem_wdata,
  input  logic [WIDTH-1:0] mem_rdata,
  output logic             busy
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  localparam logic [3:0] LAT = 4'(MEM_LAT);

  state_t     state, state_nxt;
  logic [3:0] cnt;
  logic       owner;
  logic       last_owner;
  logic       txn_we;
  logic       winner;
  logic       grant;

  // On a tie the requester that did not own the previous transaction wins.
  assign winner = (if_req & dm_req) ? ~last_owner : dm_req;
  // Gated by reset so nothing is granted while the block is held in reset.
  assign grant  = (state == S_IDLE) & (if_req | dm_req) & reset;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (grant) state_nxt = S_WAIT;
      S_WAIT:  if (cnt == LAT) state_nxt = S_RESP;
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt        <= '0;
      owner      <= 1'b0;
      last_owner <= 1'b1;
      txn_we     <= 1'b0;
      rdata      <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (grant) begin
            cnt        <= 4'd1;
            owner      <= winner;
            last_owner <= winner;
            txn_we     <= winner & dm_we;
          end
        end
        S_WAIT: begin
          cnt <= cnt + 4'd1;
          // Stores only need the ack; the shared read register keeps its last load.
          if (cnt == LAT && !txn_we) rdata <= mem_rdata;
        end
        default: cnt <= '0;
      endcase
    end
  end

  always_comb begin
    if_gnt    = grant & ~winner;
    dm_gnt    = grant & winner;
    mem_en    = grant;
    mem_we    = grant & winner & dm_we;
    sel       = grant ? winner : owner;
    if_rvalid = (state == S_RESP) & ~owner;
    dm_rvalid = (state == S_RESP) & owner;
    busy      = (state != S_IDLE);
    mem_addr  = sel ? dm_addr : if_addr;
    mem_wdata = dm_wdata;
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
// Per-cycle vector table plus directed sequences for tie, busy, reset and dropped-request cases.
module tb_mem_port_arbiter;

  localparam int WIDTH = 32;
  localparam logic [31:0] IA = 32'h0040_0000;

  logic             clk = 1'b0;
  logic             reset;
  logic             if_req;
  logic [WIDTH-1:0] if_addr;
  logic             if_gnt;
  logic             if_rvalid;
  logic             dm_req;
  logic             dm_we;
  logic [WIDTH-1:0] dm_addr;
  logic [WIDTH-1:0] dm_wdata;
  logic             dm_gnt;
  logic             dm_rvalid;
  logic [WIDTH-1:0] rdata;
  logic             sel;
  logic             mem_en;
  logic             mem_we;
  logic [WIDTH-1:0] mem_addr;
  logic [WIDTH-1:0] mem_wdata;
  logic [WIDTH-1:0] mem_rdata;
  logic             busy;

  int n_checks = 0;
  int n_fail   = 0;

  mem_port_arbiter #(.WIDTH(WIDTH), .MEM_LAT(2)) dut (
    .clk       (clk),
    .reset     (reset),
    .if_req    (if_req),
    .if_addr   (if_addr),
    .if_gnt    (if_gnt),
    .if_rvalid (if_rvalid),
    .dm_req    (dm_req),
    .dm_we     (dm_we),
    .dm_addr   (dm_addr),
    .dm_wdata  (dm_wdata),
    .dm_gnt    (dm_gnt),
    .dm_rvalid (dm_rvalid),
    .rdata     (rdata),
    .sel       (sel),
    .mem_en    (mem_en),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_rdata (mem_rdata),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        ireq;
    logic [31:0] iaddr;
    logic        dreq;
    logic        dwe;
    logic [31:0] daddr;
    logic [31:0] dwdata;
    logic [31:0] mrdata;
    logic        e_ignt;
    logic        e_dgnt;
    logic        e_irv;
    logic        e_drv;
    logic        e_sel;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic        e_busy;
    logic [31:0] e_rdata;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic clear_inputs();
    if_req = 1'b0; if_addr = IA; dm_req = 1'b0; dm_we = 1'b0;
    dm_addr = '0; dm_wdata = '0; mem_rdata = '0;
  endtask

  // Leaves the bench just after a rising edge with reset released: the start of cycle 0.
  task automatic do_reset();
    clear_inputs();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic next_cycle();
    @(posedge clk); #1;
  endtask

  initial begin
    vecs[0]  = '{1'b1, IA, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, IA, 1'b0, 32'h0};
    vecs[1]  = '{1'b0, IA, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IA, 1'b1, 32'h0};
    vecs[2]  = '{1'b0, IA, 1'b0, 1'b0, 32'h0, 32'h0, 32'h2010000A,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, IA, 1'b1, 32'h0};
    vecs[3]  = '{1'b0, IA, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, IA, 1'b1, 32'h2010000A};
    vecs[4]  = '{1'b0, IA, 1'b1, 1'b1, 32'h10010000, 32'hDEADBEEF, 32'h0,
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h10010000, 1'b0, 32'h2010000A};
    vecs[5]  = '{1'b0, IA, 1'b0, 1'b1, 32'h10010000, 32'hDEADBEEF, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10010000, 1'b1, 32'h2010000A};
    vecs[6]  = '{1'b0, IA, 1'b0, 1'b1, 32'h10010000, 32'hDEADBEEF, 32'h55555555,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10010000, 1'b1, 32'h2010000A};
    vecs[7]  = '{1'b0, IA, 1'b0, 1'b1, 32'h10010000, 32'hDEADBEEF, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10010000, 1'b1, 32'h2010000A};
    vecs[8]  = '{1'b0, IA, 1'b1, 1'b0, 32'h10010004, 32'h0, 32'h0,
                 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h10010004, 1'b0, 32'h2010000A};
    vecs[9]  = '{1'b0, IA, 1'b0, 1'b0, 32'h10010004, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10010004, 1'b1, 32'h2010000A};
    vecs[10] = '{1'b0, IA, 1'b0, 1'b0, 32'h10010004, 32'h0, 32'hCAFEF00D,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10010004, 1'b1, 32'h2010000A};
    vecs[11] = '{1'b0, IA, 1'b0, 1'b0, 32'h10010004, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h10010004, 1'b1, 32'hCAFEF00D};
    vecs[12] = '{1'b0, IA, 1'b0, 1'b0, 32'h10010004, 32'h0, 32'h0,
                 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h10010004, 1'b0, 32'hCAFEF00D};

    // Reset state, with both requests asserted to show nothing is granted under reset.
    clear_inputs();
    reset = 1'b0;
    if_req = 1'b1; dm_req = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_if_gnt", 32'(if_gnt), 32'h0);
    chk("rst_dm_gnt", 32'(dm_gnt), 32'h0);
    chk("rst_mem_en", 32'(mem_en), 32'h0);
    chk("rst_mem_we", 32'(mem_we), 32'h0);
    chk("rst_sel", 32'(sel), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_rvalid", 32'({if_rvalid, dm_rvalid}), 32'h0);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_mem_addr", mem_addr, IA);

    // Table: IF read, DM store, DM load, idle.
    do_reset();
    for (int i = 0; i < 13; i++) begin
      if_req = vecs[i].ireq; if_addr = vecs[i].iaddr; dm_req = vecs[i].dreq;
      dm_we = vecs[i].dwe; dm_addr = vecs[i].daddr; dm_wdata = vecs[i].dwdata;
      mem_rdata = vecs[i].mrdata;
      @(negedge clk);
      chk($sformatf("v%0d_if_gnt", i), 32'(if_gnt), 32'(vecs[i].e_ignt));
      chk($sformatf("v%0d_dm_gnt", i), 32'(dm_gnt), 32'(vecs[i].e_dgnt));
      chk($sformatf("v%0d_if_rvalid", i), 32'(if_rvalid), 32'(vecs[i].e_irv));
      chk($sformatf("v%0d_dm_rvalid", i), 32'(dm_rvalid), 32'(vecs[i].e_drv));
      chk($sformatf("v%0d_sel", i), 32'(sel), 32'(vecs[i].e_sel));
      chk($sformatf("v%0d_mem_en", i), 32'(mem_en), 32'(vecs[i].e_en));
      chk($sformatf("v%0d_mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
      chk($sformatf("v%0d_mem_addr", i), mem_addr, vecs[i].e_addr);
      chk($sformatf("v%0d_mem_wdata", i), mem_wdata, vecs[i].dwdata);
      chk($sformatf("v%0d_busy", i), 32'(busy), 32'(vecs[i].e_busy));
      chk($sformatf("v%0d_rdata", i), rdata, vecs[i].e_rdata);
      next_cycle();
    end

    // Tie held from reset release: grants strictly alternate, IF first.
    do_reset();
    if_req = 1'b1; dm_req = 1'b1; dm_addr = 32'h10010008;
    for (int c = 0; c < 16; c++) begin
      @(negedge clk);
      chk($sformatf("alt%0d_if_gnt", c), 32'(if_gnt), 32'(c == 0 || c == 8));
      chk($sformatf("alt%0d_dm_gnt", c), 32'(dm_gnt), 32'(c == 4 || c == 12));
      chk($sformatf("alt%0d_if_rvalid", c), 32'(if_rvalid), 32'(c == 3 || c == 11));
      chk($sformatf("alt%0d_dm_rvalid", c), 32'(dm_rvalid), 32'(c == 7 || c == 15));
      next_cycle();
    end

    // DM request arriving during an IF transaction waits for IDLE.
    do_reset();
    if_req = 1'b1;
    @(negedge clk);
    chk("busy_req_if_gnt", 32'(if_gnt), 32'h1);
    next_cycle();
    if_req = 1'b0; dm_req = 1'b1; dm_addr = 32'h1001000C;
    for (int c = 1; c <= 4; c++) begin
      @(negedge clk);
      chk($sformatf("busy_req%0d_dm_gnt", c), 32'(dm_gnt), 32'(c == 4));
      next_cycle();
    end
    dm_req = 1'b0;
    repeat (4) next_cycle();

    // Reset during a DM load discards the in-flight response.
    do_reset();
    dm_req = 1'b1; dm_we = 1'b0; dm_addr = 32'h10010010; mem_rdata = 32'h12345678;
    next_cycle();
    dm_req = 1'b0;
    repeat (2) next_cycle();
    @(negedge clk);
    chk("midrst_pre_rdata", rdata, 32'h12345678);
    chk("midrst_pre_dm_rvalid", 32'(dm_rvalid), 32'h1);
    next_cycle();
    dm_req = 1'b1;
    @(negedge clk);
    chk("midrst_gnt", 32'(dm_gnt), 32'h1);
    next_cycle();
    dm_req = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk("midrst_busy", 32'(busy), 32'h0);
    chk("midrst_rvalid", 32'({if_rvalid, dm_rvalid}), 32'h0);
    chk("midrst_rdata", rdata, 32'h0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("midrst_post%0d_rvalid", c), 32'({if_rvalid, dm_rvalid}), 32'h0);
      chk($sformatf("midrst_post%0d_busy", c), 32'(busy), 32'h0);
      next_cycle();
    end
    if_req = 1'b1; dm_req = 1'b1;
    @(negedge clk);
    chk("midrst_tie_if_gnt", 32'(if_gnt), 32'h1);
    chk("midrst_tie_dm_gnt", 32'(dm_gnt), 32'h0);
    next_cycle();
    if_req = 1'b0; dm_req = 1'b0;
    repeat (4) next_cycle();

    // DM request pulsed only while busy is never serviced.
    do_reset();
    if_req = 1'b1;
    next_cycle();
    if_req = 1'b0; dm_req = 1'b1; dm_we = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      chk($sformatf("drop%0d_dm_gnt", c), 32'(dm_gnt), 32'h0);
      chk($sformatf("drop%0d_mem_en", c), 32'(mem_en), 32'h0);
      chk($sformatf("drop%0d_dm_rvalid", c), 32'(dm_rvalid), 32'h0);
      next_cycle();
      dm_req = 1'b0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Sequences a single shared 32-bit memory port between instruction fetch (IF) and data memory (DM) in the MIPS core.
- Drives the select of the 32-bit 2:1 address/data mux in front of the memory.
- Round-robin between the two requesters, one outstanding transaction.
- Fixed memory read latency; returns a response pulse to the owning requester.

Parameters:
- WIDTH, 32, address/data width.
- MEM_LAT, 2, cycles from mem_en to mem_rdata valid; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- if_req  in  1  fetch request; held until if_gnt.
- if_addr  in  WIDTH  fetch address.
- if_gnt  out  1  fetch accepted this cycle.
- if_rvalid  out  1  fetch response pulse; rdata valid.
- dm_req  in  1  data request; held until dm_gnt.
- dm_we  in  1  1 = store, 0 = load.
- dm_addr  in  WIDTH  data address.
- dm_wdata  in  WIDTH  store data.
- dm_gnt  out  1  data accepted this cycle.
- dm_rvalid  out  1  data response pulse (load data or store ack).
- rdata  out  WIDTH  shared response data register.
- sel  out  1  mux select: 0 = IF, 1 = DM.
- mem_en  out  1  memory access strobe.
- mem_we  out  1  memory write enable.
- mem_addr  out  WIDTH  muxed address.
- mem_wdata  out  WIDTH  store data (dm_wdata).
- mem_rdata  in  WIDTH  memory read data.
- busy  out  1  transaction in flight (state != IDLE).

Behaviour:
- FSM states:
  - IDLE: if any request, grant it and go to WAIT with cnt = 1.
  - WAIT: cnt increments each cycle. When cnt == MEM_LAT, capture mem_rdata into rdata (loads only) and go to RESP.
  - RESP: one cycle; owner's rvalid = 1; then go to IDLE.
- Arbitration in IDLE:
  - Only one request active: grant it.
  - Both active: grant the requester that is not last_owner.
  - last_owner updates on every grant.
- Grant cycle (cycle 0), all combinational from IDLE and the choice:
  - gnt of the winner = 1, mem_en = 1.
  - sel = winner; mem_addr = sel ? dm_addr : if_addr.
  - mem_we = sel & dm_we; mem_wdata = dm_wdata.
- Owner register:
  - Captures the winner at grant.
  - sel = owner in WAIT/RESP.
  - In IDLE with no request, sel = owner.
- mem_en and gnt are 0 outside the grant cycle.
- Memory contract: mem_rdata is valid in cycle MEM_LAT; rdata/rvalid become visible in cycle MEM_LAT+1.
- Earliest next grant is cycle MEM_LAT+2.
- Stores: dm_rvalid pulses in cycle MEM_LAT+1 as the ack; rdata is not updated.
- cnt width: 4 bits.
- Reset values: state IDLE, cnt 0, owner 0, rdata 0, both rvalid 0, last_owner 1 (IF wins the first tie).
  - All outputs 0 during reset, except mem_addr/mem_wdata, which follow the mux.
- Requests during WAIT/RESP: ignored, no gnt; they are serviced in IDLE.
- Request deasserted before gnt: nothing issued, no state change.
- Reset mid-transaction:
  - Immediate abort to the reset values.
  - The in-flight memory response is discarded; no rvalid after release.
- At most one of if_rvalid/dm_rvalid is ever high; gnt and rvalid are never high together.
- No starvation: with both requesting continuously, grants strictly alternate.

Test Plan:
- MEM_LAT=2 throughout.
- IF-only read:
  - Stimulus: if_req=1, if_addr=0x00400000 after reset release; mem_rdata=0x2010000A in cycle 2.
  - Required: cycle 0 shows if_gnt=1, mem_en=1, sel=0, mem_addr=0x00400000. Cycle 3 shows if_rvalid=1, rdata=0x2010000A. busy=1 in cycles 1–3.
- DM store:
  - Stimulus: dm_req=1, dm_we=1, dm_addr=0x10010000, dm_wdata=0xDEADBEEF.
  - Required: grant cycle shows sel=1, mem_we=1, mem_addr=0x10010000, mem_wdata=0xDEADBEEF. dm_rvalid=1 in cycle 3. rdata unchanged.
- Tie and alternation:
  - Stimulus: if_req and dm_req both held high from reset release.
  - Required: grants IF at cycle 0, DM at cycle 4, IF at cycle 8, DM at cycle 12. rvalid pulses in cycles 3, 7, 11, 15 for the matching owner.
- Request while busy:
  - Stimulus: dm_req rises in cycle 1 of an IF transaction.
  - Required: no dm_gnt before cycle 4; dm_gnt=1 exactly at cycle 4.
- Reset mid-operation:
  - Stimulus: reset=0 in cycle 1 of a DM load; release 2 cycles later.
  - Required: busy/rvalid/rdata=0 immediately; no rvalid afterwards. A subsequent simultaneous request grants IF first.
- Dropped request:
  - Stimulus: dm_req pulses high only during a busy cycle.
  - Required: no dm_gnt, no mem_en, no dm_rvalid.
